// File: rtl/guess_pkg.sv
// Shared constants for the guess-entry keypad: key indices, key codes and debounce default.
package guess_pkg;

  localparam int unsigned NUM_KEYS           = 5;
  localparam int unsigned KEY_I1             = 0;
  localparam int unsigned KEY_I2             = 1;
  localparam int unsigned KEY_I3             = 2;
  localparam int unsigned KEY_I4             = 3;
  localparam int unsigned KEY_ENTER          = 4;
  localparam int unsigned DEB_CYCLES_DEFAULT = 16;

  typedef enum logic [2:0] {
    CodeNone  = 3'd0,
    CodeI1    = 3'd1,
    CodeI2    = 3'd2,
    CodeI3    = 3'd3,
    CodeI4    = 3'd4,
    CodeEnter = 3'd5
  } key_code_e;

  // Key index 0..4 maps onto code 1..5.
  function automatic key_code_e key_code_of(input int unsigned idx);
    return key_code_e'(3'(idx + 1));
  endfunction

endpackage

// File: rtl/debounce_cell.sv
// One key: synchronizer chain, debounce counter and stable level; flags a debounced rising edge.
module debounce_cell #(
  parameter int unsigned DEB_CYCLES  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_rise
);

  localparam int unsigned    CntW   = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_stable;
  logic [CntW-1:0]        r_cnt;
  logic                   w_sync;
  logic                   w_differ;
  logic                   w_flip;

  assign w_sync   = r_sync[SYNC_STAGES-1];
  assign w_differ = (w_sync != r_stable);
  assign w_flip   = w_differ && (r_cnt == CntMax);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync   <= '0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
      // Any sample matching the stable level restarts qualification.
      if (!w_differ || w_flip) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_flip) begin
        r_stable <= w_sync;
      end
    end
  end

  assign o_rise = w_flip & w_sync;

endmodule

// File: rtl/key_conditioner.sv
// Debounces five push buttons and issues one-cycle press pulses, one key per cycle, I1 first.
module key_conditioner
  import guess_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = DEB_CYCLES_DEFAULT,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       raw_I1,
  input  logic       raw_I2,
  input  logic       raw_I3,
  input  logic       raw_I4,
  input  logic       raw_enter,
  output logic       I1,
  output logic       I2,
  output logic       I3,
  output logic       I4,
  output logic       enter,
  output logic [2:0] key_code,
  output logic       any_pending
);

  logic [NUM_KEYS-1:0] w_raw;
  logic [NUM_KEYS-1:0] w_rise;
  logic [NUM_KEYS-1:0] w_grant;
  logic [NUM_KEYS-1:0] r_pend;
  logic [NUM_KEYS-1:0] r_pulse;
  key_code_e           w_code;
  logic [2:0]          r_code;
  logic                w_found;

  assign w_raw[KEY_I1]    = raw_I1;
  assign w_raw[KEY_I2]    = raw_I2;
  assign w_raw[KEY_I3]    = raw_I3;
  assign w_raw[KEY_I4]    = raw_I4;
  assign w_raw[KEY_ENTER] = raw_enter;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_cell
    debounce_cell #(
      .DEB_CYCLES (DEB_CYCLES),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_cell (
      .clk   (clk),
      .reset (reset),
      .i_raw (w_raw[g]),
      .o_rise(w_rise[g])
    );
  end

  always_comb begin
    w_grant = '0;
    w_code  = CodeNone;
    w_found = 1'b0;
    for (int unsigned k = 0; k < NUM_KEYS; k++) begin
      if (r_pend[k] && !w_found) begin
        w_grant[k] = 1'b1;
        w_code     = key_code_of(k);
        w_found    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend  <= '0;
      r_pulse <= '0;
      r_code  <= '0;
    end else begin
      // A new rise wins over the grant clearing the same bit.
      r_pend  <= (r_pend & ~w_grant) | w_rise;
      r_pulse <= w_grant;
      r_code  <= w_code;
    end
  end

  assign I1          = r_pulse[KEY_I1];
  assign I2          = r_pulse[KEY_I2];
  assign I3          = r_pulse[KEY_I3];
  assign I4          = r_pulse[KEY_I4];
  assign enter       = r_pulse[KEY_ENTER];
  assign key_code    = r_code;
  assign any_pending = |r_pend;

endmodule
